// File: rtl/ibex_pext_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module : ibex_pkg_pext
// Brief  : Zpn operation encodings, KMMAWB FSM states, lane helpers.
// Rev    : 1.0
// ============================================================================
package ibex_pkg_pext;

    localparam int LANES16 = 2;
    localparam int LANES8  = 4;

    typedef enum logic [3:0] {
        ZPN_ADD16  = 4'd0,
        ZPN_SUB16  = 4'd1,
        ZPN_ADD8   = 4'd2,
        ZPN_SUB8   = 4'd3,
        ZPN_KADD16 = 4'd4,
        ZPN_KSUB16 = 4'd5,
        ZPN_RADD16 = 4'd6,
        ZPN_SRA16I = 4'd7,
        ZPN_SLL16I = 4'd8,
        ZPN_SMAX16 = 4'd9,
        ZPN_SMIN16 = 4'd10,
        ZPN_KMMAWB = 4'd11
    } zpn_op_e;

    typedef enum logic [0:0] {
        MUL_IDLE = 1'b0,
        MUL_2    = 1'b1
    } mul_state_e;

    // Returns {clamped, value}: a 17-bit signed sum squeezed into 16 bits.
    function automatic logic [16:0] sat16(input logic [16:0] v);
        if (v[16] != v[15]) begin
            return v[16] ? {1'b1, 16'h8000} : {1'b1, 16'h7fff};
        end
        return {1'b0, v[15:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ibex_pext_mul16.sv
`default_nettype none
// ============================================================================
// Module : ibex_pext_mul16
// Brief  : Signed 17x16 multiplier with a full 33-bit product.
// Rev    : 1.0
// ============================================================================
module ibex_pext_mul16 (
    input  logic [16:0] op_a,
    input  logic [15:0] op_b,
    output logic [32:0] prod
);

    assign prod = 33'($signed(op_a) * $signed(op_b));

endmodule
`default_nettype wire

// File: rtl/ibex_pext_alu.sv
`default_nettype none
// ============================================================================
// Module : ibex_pext_alu
// Brief  : Packed-SIMD Zpn ALU; KMMAWB (2-cycle) built only with PEXT_MULT_EN.
// Rev    : 1.0
// ============================================================================
module ibex_pext_alu
    import ibex_pkg_pext::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          zpn_instr_i,
    input  zpn_op_e       zpn_operator_i,
    input  logic          mult_en_i,
    input  logic [31:0]   operand_a_i,
    input  logic [31:0]   operand_b_i,
    input  logic [31:0]   operand_rd_i,
    input  logic [4:0]    imm_val_i,
    input  logic [33:0]   imd_val_q_i [2],
    output logic [33:0]   imd_val_d_o [2],
    output logic [1:0]    imd_val_we_o,
    output logic [31:0]   result_o,
    output logic          valid_o,
    output logic          set_ov_o
);

    logic [31:0] res16;
    logic [31:0] res8;
    logic        ov16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic [16:0] sum17;
    logic [16:0] dif17;
    logic [16:0] sat;
    logic [3:0]  shamt;

    assign shamt = imm_val_i[3:0];

    always_comb begin
        res16 = '0;
        res8  = '0;
        ov16  = 1'b0;
        a16   = '0;
        b16   = '0;
        sum17 = '0;
        dif17 = '0;
        sat   = '0;
        for (int i = 0; i < LANES16; i++) begin
            a16   = operand_a_i[16*i +: 16];
            b16   = operand_b_i[16*i +: 16];
            sum17 = {a16[15], a16} + {b16[15], b16};
            dif17 = {a16[15], a16} - {b16[15], b16};
            case (zpn_operator_i)
                ZPN_ADD16: res16[16*i +: 16] = a16 + b16;
                ZPN_SUB16: res16[16*i +: 16] = a16 - b16;
                ZPN_KADD16, ZPN_KSUB16: begin
                    sat = sat16((zpn_operator_i == ZPN_KADD16) ? sum17 : dif17);
                    res16[16*i +: 16] = sat[15:0];
                    ov16 = ov16 | sat[16];
                end
                ZPN_RADD16: res16[16*i +: 16] = sum17[16:1];
                ZPN_SRA16I: res16[16*i +: 16] = $signed(a16) >>> shamt;
                ZPN_SLL16I: res16[16*i +: 16] = a16 << shamt;
                ZPN_SMAX16: res16[16*i +: 16] = ($signed(a16) > $signed(b16)) ? a16 : b16;
                ZPN_SMIN16: res16[16*i +: 16] = ($signed(a16) < $signed(b16)) ? a16 : b16;
                default:    res16[16*i +: 16] = 16'h0000;
            endcase
        end
        for (int j = 0; j < LANES8; j++) begin
            res8[8*j +: 8] = (zpn_operator_i == ZPN_SUB8)
                           ? operand_a_i[8*j +: 8] - operand_b_i[8*j +: 8]
                           : operand_a_i[8*j +: 8] + operand_b_i[8*j +: 8];
        end
    end

`ifdef PEXT_MULT_EN
    mul_state_e   state;
    logic [16:0]  mul_a;
    logic [32:0]  prod;
    logic [33:0]  imd_shift;
    logic [33:0]  mac34;
    logic [33:0]  tot;
    logic         mul_ov;
    logic [31:0]  mul_res;
    logic         kmmawb_go;

    // Cycle 1 multiplies the zero-extended low half of a, cycle 2 the signed high half.
    assign mul_a = (state == MUL_IDLE) ? {1'b0, operand_a_i[15:0]}
                                       : {operand_a_i[31], operand_a_i[31:16]};

    ibex_pext_mul16 u_mul16 (
        .op_a (mul_a),
        .op_b (operand_b_i[15:0]),
        .prod (prod)
    );

    assign imd_shift = $signed(imd_val_q_i[0]) >>> 16;
    assign mac34     = $signed({prod[32], prod}) + $signed(imd_shift);
    assign tot       = {{2{operand_rd_i[31]}}, operand_rd_i} + mac34;
    assign mul_ov    = (tot[33:31] != 3'b000) && (tot[33:31] != 3'b111);
    assign mul_res   = mul_ov ? (tot[33] ? 32'h8000_0000 : 32'h7fff_ffff) : tot[31:0];
    assign kmmawb_go = zpn_instr_i && (zpn_operator_i == ZPN_KMMAWB) && mult_en_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= MUL_IDLE;
        end else if ((state == MUL_IDLE) && kmmawb_go) begin
            state <= MUL_2;
        end else begin
            state <= MUL_IDLE;
        end
    end

    assign imd_val_d_o[0] = {prod[32], prod};

    logic unused_sink;
    assign unused_sink = ^{imm_val_i[4], imd_val_q_i[1]};
`else
    assign imd_val_d_o[0] = '0;

    logic unused_sink;
    assign unused_sink = ^{clk_i, mult_en_i, imm_val_i[4], operand_rd_i,
                           imd_val_q_i[0], imd_val_q_i[1]};
`endif

    assign imd_val_d_o[1] = '0;

    always_comb begin
        result_o     = '0;
        valid_o      = 1'b0;
        set_ov_o     = 1'b0;
        imd_val_we_o = 2'b00;
        if (zpn_instr_i && !rst_i) begin
            case (zpn_operator_i)
                ZPN_ADD8, ZPN_SUB8: begin
                    result_o = res8;
                    valid_o  = 1'b1;
                end
                ZPN_KMMAWB: begin
`ifdef PEXT_MULT_EN
                    if (mult_en_i) begin
                        if (state == MUL_IDLE) begin
                            imd_val_we_o = 2'b01;
                        end else begin
                            result_o = mul_res;
                            valid_o  = 1'b1;
                            set_ov_o = mul_ov;
                        end
                    end
`else
                    valid_o = 1'b1;
`endif
                end
                default: begin
                    result_o = res16;
                    valid_o  = 1'b1;
                    set_ov_o = ov16;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ibex_pext_alu.sv
`default_nettype none
// ============================================================================
// Module : tb_ibex_pext_alu
// Brief  : Directed self-checking bench for ibex_pext_alu (PEXT_MULT_EN aware).
// Rev    : 1.0
// ============================================================================
module tb_ibex_pext_alu;
    import ibex_pkg_pext::*;

    logic        clk;
    logic        rst;
    logic        zpn_instr;
    zpn_op_e     op;
    logic        mult_en;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rd;
    logic [4:0]  imm;
    logic [33:0] imd_q [2];
    logic [33:0] imd_d [2];
    logic [1:0]  imd_we;
    logic [31:0] result;
    logic        valid;
    logic        set_ov;

    int n_checks = 0;
    int n_errors = 0;

    ibex_pext_alu dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .zpn_instr_i    (zpn_instr),
        .zpn_operator_i (op),
        .mult_en_i      (mult_en),
        .operand_a_i    (a),
        .operand_b_i    (b),
        .operand_rd_i   (rd),
        .imm_val_i      (imm),
        .imd_val_q_i    (imd_q),
        .imd_val_d_o    (imd_d),
        .imd_val_we_o   (imd_we),
        .result_o       (result),
        .valid_o        (valid),
        .set_ov_o       (set_ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the core's intermediate-value registers.
    always_ff @(posedge clk) begin
        imd_q[1] <= '0;
        if (rst) begin
            imd_q[0] <= '0;
        end else if (imd_we[0]) begin
            imd_q[0] <= imd_d[0];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic apply(input zpn_op_e o, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] vrd, input logic [4:0] vimm, input logic men);
        @(posedge clk);
        #1;
        zpn_instr = 1'b1;
        op        = o;
        a         = va;
        b         = vb;
        rd        = vrd;
        imm       = vimm;
        mult_en   = men;
        @(negedge clk);
    endtask

    task automatic single(input string tag, input zpn_op_e o, input logic [31:0] va,
                          input logic [31:0] vb, input logic [4:0] vimm,
                          input logic [31:0] exp_res, input logic exp_ov);
        apply(o, va, vb, 32'h0, vimm, 1'b0);
        check({tag, "_res"}, 64'(result), 64'(exp_res));
        check({tag, "_vld_ov"}, 64'({valid, set_ov}), 64'({1'b1, exp_ov}));
    endtask

    initial begin
        rst = 1'b1; zpn_instr = 1'b1; op = ZPN_ADD16; mult_en = 1'b0;
        a = 32'hffff0001; b = 32'h00010001; rd = '0; imm = '0;
        @(posedge clk);
        @(negedge clk);
        check("reset_outs", 64'({result, valid, set_ov, imd_we}), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        zpn_instr = 1'b0;
        @(negedge clk);
        check("no_instr", 64'({result, valid, set_ov, imd_we}), 64'(0));

        single("add16",   ZPN_ADD16,  32'hffff0001, 32'h00010001, 5'd0, 32'h00000002, 1'b0);
        single("add8",    ZPN_ADD8,   32'h80ff7f01, 32'h80017f01, 5'd0, 32'h0000fe02, 1'b0);
        single("sub16",   ZPN_SUB16,  32'h00000001, 32'h00000002, 5'd0, 32'h0000ffff, 1'b0);
        single("sub8",    ZPN_SUB8,   32'h00000100, 32'h00000001, 5'd0, 32'h000001ff, 1'b0);
        single("kadd16",  ZPN_KADD16, 32'h7fff8000, 32'h0001ffff, 5'd0, 32'h7fff8000, 1'b1);
        single("kadd_ok", ZPN_KADD16, 32'h12340001, 32'h00010002, 5'd0, 32'h12350003, 1'b0);
        single("ksub16",  ZPN_KSUB16, 32'h80000000, 32'h00017fff, 5'd0, 32'h80008001, 1'b1);
        single("radd16",  ZPN_RADD16, 32'h7fff0003, 32'h7fff0001, 5'd0, 32'h7fff0002, 1'b0);
        single("sra16i",  ZPN_SRA16I, 32'h80000010, 32'h0, 5'd4,  32'hf8000001, 1'b0);
        single("sra_i4",  ZPN_SRA16I, 32'h80000010, 32'h0, 5'h14, 32'hf8000001, 1'b0);
        single("sll16i",  ZPN_SLL16I, 32'h80014000, 32'h0, 5'd1,  32'h00028000, 1'b0);
        single("smax16",  ZPN_SMAX16, 32'h80000005, 32'h7ffffffb, 5'd0, 32'h7fff0005, 1'b0);
        single("smin16",  ZPN_SMIN16, 32'h80000005, 32'h7ffffffb, 5'd0, 32'h8000fffb, 1'b0);

`ifdef PEXT_MULT_EN
        apply(ZPN_KMMAWB, 32'h67543476, 32'h0000ffff, 32'h00000011, 5'd0, 1'b1);
        check("mac1_c1", 64'({valid, imd_we}), 64'({1'b0, 2'b01}));
        check("imd1_zero", 64'(imd_d[1]), 64'(0));
        apply(ZPN_KMMAWB, 32'h67543476, 32'h0000ffff, 32'h00000011, 5'd0, 1'b1);
        check("mac1_c2", 64'({result, valid, set_ov, imd_we}), 64'({32'hffff98bc, 1'b1, 1'b0, 2'b00}));

        apply(ZPN_KMMAWB, 32'h7fffffff, 32'h00007fff, 32'h7fffffff, 5'd0, 1'b1);
        check("mac2_c1", 64'({valid, imd_we}), 64'({1'b0, 2'b01}));
        apply(ZPN_KMMAWB, 32'h7fffffff, 32'h00007fff, 32'h7fffffff, 5'd0, 1'b1);
        check("mac2_c2", 64'({result, valid, set_ov}), 64'({32'h7fffffff, 1'b1, 1'b1}));

        // Reset lands on the second cycle: no result, then a clean restart.
        apply(ZPN_KMMAWB, 32'h67543476, 32'h0000ffff, 32'h00000011, 5'd0, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid", 64'({result, valid, set_ov, imd_we}), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("restart_c1", 64'({valid, imd_we}), 64'({1'b0, 2'b01}));
        apply(ZPN_KMMAWB, 32'h67543476, 32'h0000ffff, 32'h00000011, 5'd0, 1'b1);
        check("restart_c2", 64'({result, valid, set_ov}), 64'({32'hffff98bc, 1'b1, 1'b0}));

        // Dropping mult_en in the second cycle abandons the op.
        apply(ZPN_KMMAWB, 32'h00010000, 32'h00000002, 32'h0, 5'd0, 1'b1);
        apply(ZPN_KMMAWB, 32'h00010000, 32'h00000002, 32'h0, 5'd0, 1'b0);
        check("abort", 64'({valid, imd_we}), 64'(0));
        apply(ZPN_KMMAWB, 32'h00010000, 32'h00000002, 32'h5, 5'd0, 1'b1);
        check("post_abort_c1", 64'({valid, imd_we}), 64'({1'b0, 2'b01}));
        apply(ZPN_KMMAWB, 32'h00010000, 32'h00000002, 32'h5, 5'd0, 1'b1);
        check("post_abort_c2", 64'({result, valid, set_ov}), 64'({32'h00000007, 1'b1, 1'b0}));
`else
        apply(ZPN_KMMAWB, 32'h67543476, 32'h0000ffff, 32'h00000011, 5'd0, 1'b1);
        check("mac_off", 64'({result, valid, set_ov, imd_we}), 64'({32'h0, 1'b1, 1'b0, 2'b00}));
        check("imd_off", 64'({imd_d[0], imd_d[1]}), 64'(0));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
